// File: rtl/quadrature_sampler.sv
// -----------------------------------------------------------------------------
// quadrature_sampler
//
// Sequences the quadrature decoder's displacement counter. Every programmed
// period it snapshots the running displacement and publishes the signed change
// since the previous snapshot (a velocity sample) on a valid/ready stream.
// It also watches the decoder's hw_err strobe, parks in FAULT, and on host
// request runs a recovery step that pulses clear_displacement to zero the
// decoder count.
//
// Build option:
//   QUAD_SAMPLER_STALL_EN  when defined, counts consecutive zero-delta samples
//                          and raises stall after STALL_SAMPLES of them.
//                          When undefined, stall is tied low.
//
// Ports:
//   clk                 in   system clock
//   rst_n               in   synchronous active-low reset
//   enable              in   1 = run periodic sampling
//   period              in   sample period in clk cycles (0 treated as 1),
//                            latched when leaving IDLE
//   displacement        in   decoder running count (two's complement, wraps)
//   hw_err              in   decoder illegal-transition strobe
//   clear_displacement  out  one-cycle pulse zeroing the decoder count
//   fault_clear         in   host request to leave FAULT
//   sample_delta        out  signed displacement change over the last period
//   sample_valid        out  sample_delta holds an unconsumed sample
//   sample_ready        in   consumer accepts when sample_valid & sample_ready
//   sample_overrun      out  sticky: an unconsumed sample was overwritten
//   fault               out  1 while in FAULT
//   stall               out  motion stalled (stall option only)
//   dbg_state           out  current FSM state encoding
//
// Stream handshake: a sample transfers on any clock edge where sample_valid
// and sample_ready are both high. sample_delta is stable while sample_valid
// is high unless a newer sample overwrites it, which sets sample_overrun
// (except when the old sample is accepted on that same edge).
// -----------------------------------------------------------------------------
module quadrature_sampler #(
   parameter int COUNTER_WIDTH = 32,
   parameter int STALL_SAMPLES = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [COUNTER_WIDTH-1:0] period,
   input  logic [COUNTER_WIDTH-1:0] displacement,
   input  logic                     hw_err,
   output logic                     clear_displacement,
   input  logic                     fault_clear,
   output logic [COUNTER_WIDTH-1:0] sample_delta,
   output logic                     sample_valid,
   input  logic                     sample_ready,
   output logic                     sample_overrun,
   output logic                     fault,
   output logic                     stall,
   output logic [2:0]               dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_RUN     = 3'd2,
      S_FAULT   = 3'd3,
      S_RECOVER = 3'd4
   } state_t;

   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] period_q;
   logic [COUNTER_WIDTH-1:0] timer_q;
   logic [COUNTER_WIDTH-1:0] prev_q;
   logic [COUNTER_WIDTH-1:0] delta_q;
   logic                     valid_q;
   logic                     overrun_q;
   logic                     fault_q;
   logic                     clear_q;

   logic [COUNTER_WIDTH-1:0] period_d;
   logic [COUNTER_WIDTH-1:0] delta_d;
   logic                     sample_now_d;
   logic                     accept_d;

   always_comb begin
      period_d     = (period == '0) ? COUNTER_WIDTH'(1) : period;
      // Modular subtraction gives the correct signed delta across counter wrap.
      delta_d      = displacement - prev_q;
      // hw_err and a disabled run both suppress the sample due this cycle.
      sample_now_d = (state_q == S_RUN) && enable && !hw_err && (timer_q == '0);
      accept_d     = valid_q && sample_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         period_q  <= '0;
         timer_q   <= '0;
         prev_q    <= '0;
         delta_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         fault_q   <= 1'b0;
         clear_q   <= 1'b0;
      end else begin
         clear_q <= 1'b0;

         // Output stream: a landing sample wins over a consume on the same edge.
         if (sample_now_d) begin
            delta_q <= delta_d;
            valid_q <= 1'b1;
            if (valid_q && !sample_ready) begin
               overrun_q <= 1'b1;
            end
         end else if (accept_d) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  period_q <= period_d;
                  state_q  <= S_ARM;
               end
            end
            S_ARM: begin
               if (hw_err) begin
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else begin
                  prev_q  <= displacement;
                  timer_q <= period_q - 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (hw_err) begin
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else if (!enable) begin
                  state_q <= S_IDLE;
               end else if (timer_q == '0) begin
                  prev_q  <= displacement;
                  timer_q <= period_q - 1'b1;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            S_FAULT: begin
               // Recovery effects are applied on entry so they are visible
               // during the single RECOVER cycle alongside the clear pulse.
               if (fault_clear) begin
                  fault_q   <= 1'b0;
                  clear_q   <= 1'b1;
                  prev_q    <= '0;
                  overrun_q <= 1'b0;
                  valid_q   <= 1'b0;
                  state_q   <= S_RECOVER;
               end
            end
            S_RECOVER: begin
               state_q <= enable ? S_ARM : S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef QUAD_SAMPLER_STALL_EN
   localparam int STALL_CNT_W = $clog2(STALL_SAMPLES + 1);

   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic                   stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n || state_q == S_ARM || state_q == S_FAULT) begin
         stall_cnt_q <= '0;
         stall_q     <= 1'b0;
      end else if (sample_now_d) begin
         if (delta_d == '0) begin
            if (stall_cnt_q != STALL_CNT_W'(STALL_SAMPLES)) begin
               stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            // The sample landing now is number stall_cnt_q + 1.
            stall_q <= (stall_cnt_q >= STALL_CNT_W'(STALL_SAMPLES - 1));
         end else begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
         end
      end
   end

   assign stall = stall_q;
`else
   // Stall detection compiled out; the parameter stays referenced so both
   // builds elaborate the same interface without unused-parameter noise.
   assign stall = (STALL_SAMPLES < 0) & 1'b0;
`endif

   assign clear_displacement = clear_q;
   assign sample_delta       = delta_q;
   assign sample_valid       = valid_q;
   assign sample_overrun     = overrun_q;
   assign fault              = fault_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_quadrature_sampler.sv
// -----------------------------------------------------------------------------
// tb_quadrature_sampler
//
// Self-checking bench for quadrature_sampler. A table of per-cycle vectors
// (inputs plus hand-computed expected outputs) walks through sampling,
// negative deltas, backpressure/overrun, simultaneous accept+sample, faults
// and recovery. Hand-written sequences cover the period-10 ramp, counter wrap
// with period 0, and reset while a sample is pending.
// -----------------------------------------------------------------------------
module tb_quadrature_sampler;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic [W-1:0] period;
   logic [W-1:0] displacement;
   logic         hw_err;
   logic         clear_displacement;
   logic         fault_clear;
   logic [W-1:0] sample_delta;
   logic         sample_valid;
   logic         sample_ready;
   logic         sample_overrun;
   logic         fault;
   logic         stall;
   logic [2:0]   dbg_state;

   always #5 clk = ~clk;

   quadrature_sampler #(
      .COUNTER_WIDTH(W),
      .STALL_SAMPLES(8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .period            (period),
      .displacement      (displacement),
      .hw_err            (hw_err),
      .clear_displacement(clear_displacement),
      .fault_clear       (fault_clear),
      .sample_delta      (sample_delta),
      .sample_valid      (sample_valid),
      .sample_ready      (sample_ready),
      .sample_overrun    (sample_overrun),
      .fault             (fault),
      .stall             (stall),
      .dbg_state         (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic en, input logic [W-1:0] per,
                        input logic [W-1:0] disp, input logic herr,
                        input logic fclr, input logic rdy);
      rst_n        = r;
      enable       = en;
      period       = per;
      displacement = disp;
      hw_err       = herr;
      fault_clear  = fclr;
      sample_ready = rdy;
   endtask

   // One active edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         rst_n;
      logic         en;
      logic [W-1:0] per;
      logic [W-1:0] disp;
      logic         herr;
      logic         fclr;
      logic         rdy;
      logic         e_valid;
      logic [W-1:0] e_delta;
      logic         e_ovr;
      logic         e_fault;
      logic         e_clr;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl[NV];

   function automatic vec_t mk(input logic r, input logic en, input logic [W-1:0] per,
                               input logic [W-1:0] disp, input logic herr,
                               input logic fclr, input logic rdy,
                               input logic ev, input logic [W-1:0] ed,
                               input logic eo, input logic ef, input logic ec);
      vec_t v;
      v.rst_n = r;  v.en = en;  v.per = per;  v.disp = disp;
      v.herr = herr; v.fclr = fclr; v.rdy = rdy;
      v.e_valid = ev; v.e_delta = ed; v.e_ovr = eo; v.e_fault = ef; v.e_clr = ec;
      return v;
   endfunction

   initial begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      //             rst en per disp         he fc rd | val delta         ovr flt clr
      tbl[0]  = mk(0, 0, 2, 100,          0, 0, 0,   0, 32'd0,        0, 0, 0); // reset
      tbl[1]  = mk(1, 1, 2, 100,          0, 0, 0,   0, 32'd0,        0, 0, 0); // IDLE->ARM
      tbl[2]  = mk(1, 1, 2, 100,          0, 0, 0,   0, 32'd0,        0, 0, 0); // ARM: prev=100
      tbl[3]  = mk(1, 1, 2, 103,          0, 0, 0,   0, 32'd0,        0, 0, 0); // timer 1->0
      tbl[4]  = mk(1, 1, 2, 107,          0, 0, 0,   1, 32'd7,        0, 0, 0); // first sample
      tbl[5]  = mk(1, 1, 2, 107,          0, 0, 1,   0, 32'd7,        0, 0, 0); // consumed
      tbl[6]  = mk(1, 1, 2, 104,          0, 0, 0,   1, 32'hFFFF_FFFD, 0, 0, 0); // -3
      tbl[7]  = mk(1, 1, 2, 104,          0, 0, 0,   1, 32'hFFFF_FFFD, 0, 0, 0); // held
      tbl[8]  = mk(1, 1, 2, 110,          0, 0, 0,   1, 32'd6,        1, 0, 0); // overwrite
      tbl[9]  = mk(1, 1, 2, 110,          0, 0, 1,   0, 32'd6,        1, 0, 0); // one transfer
      tbl[10] = mk(1, 1, 2, 115,          0, 0, 1,   1, 32'd5,        1, 0, 0); // new sample
      tbl[11] = mk(1, 1, 2, 115,          0, 0, 1,   0, 32'd5,        1, 0, 0);
      tbl[12] = mk(1, 1, 2, 120,          0, 0, 0,   1, 32'd5,        1, 0, 0);
      tbl[13] = mk(1, 1, 2, 120,          0, 0, 0,   1, 32'd5,        1, 0, 0);
      tbl[14] = mk(1, 1, 2, 124,          0, 0, 1,   1, 32'd4,        1, 0, 0); // accept+land
      tbl[15] = mk(1, 1, 2, 124,          1, 0, 0,   1, 32'd4,        1, 1, 0); // hw_err
      tbl[16] = mk(1, 1, 2, 200,          0, 0, 0,   1, 32'd4,        1, 1, 0); // frozen
      tbl[17] = mk(1, 1, 2, 200,          0, 1, 0,   0, 32'd4,        0, 0, 1); // RECOVER
      tbl[18] = mk(1, 1, 2, 0,            0, 0, 0,   0, 32'd4,        0, 0, 0); // ->ARM
      tbl[19] = mk(1, 1, 2, 0,            0, 0, 0,   0, 32'd4,        0, 0, 0); // ARM: prev=0
      tbl[20] = mk(1, 1, 2, 3,            0, 0, 0,   0, 32'd4,        0, 0, 0);
      tbl[21] = mk(1, 1, 2, 5,            0, 0, 0,   1, 32'd5,        0, 0, 0); // re-armed sample
      tbl[22] = mk(1, 1, 2, 5,            0, 0, 1,   0, 32'd5,        0, 0, 0);
      tbl[23] = mk(1, 1, 2, 9,            1, 0, 0,   0, 32'd5,        0, 1, 0); // err at timer==0
      tbl[24] = mk(1, 1, 2, 9,            0, 0, 0,   0, 32'd5,        0, 1, 0);
      tbl[25] = mk(1, 0, 2, 9,            0, 1, 0,   0, 32'd5,        0, 0, 1); // RECOVER
      tbl[26] = mk(1, 0, 2, 9,            0, 0, 0,   0, 32'd5,        0, 0, 0); // ->IDLE

      // ---------------- table-driven run ----------------
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rst_n, tbl[i].en, tbl[i].per, tbl[i].disp,
               tbl[i].herr, tbl[i].fclr, tbl[i].rdy);
         tick();
         chk($sformatf("v%0d valid", i),   W'(sample_valid),       W'(tbl[i].e_valid));
         chk($sformatf("v%0d delta", i),   sample_delta,           tbl[i].e_delta);
         chk($sformatf("v%0d overrun", i), W'(sample_overrun),     W'(tbl[i].e_ovr));
         chk($sformatf("v%0d fault", i),   W'(fault),              W'(tbl[i].e_fault));
         chk($sformatf("v%0d clear", i),   W'(clear_displacement), W'(tbl[i].e_clr));
         chk($sformatf("v%0d stall", i),   W'(stall),              '0);
      end

      // ---------------- period 10, displacement +1 every 2 clk ----------------
      drive(1'b0, 1'b0, 32'd10, '0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("ramp reset valid", W'(sample_valid), '0);
      for (int c = 0; c <= 31; c++) begin
         drive(1'b1, 1'b1, 32'd10, W'(c / 2), 1'b0, 1'b0, 1'b1);
         tick();
         // Edge 0 leaves IDLE, edge 1 is ARM, samples land on edges 11, 21, 31.
         if (c == 11 || c == 21 || c == 31) begin
            chk($sformatf("ramp c%0d valid", c), W'(sample_valid), 32'd1);
            chk($sformatf("ramp c%0d delta", c), sample_delta, 32'd5);
         end else begin
            chk($sformatf("ramp c%0d valid", c), W'(sample_valid), '0);
         end
      end

      // ---------------- wrap with period 0 (sample every cycle) ----------------
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, '0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      tick();                                  // IDLE -> ARM
      tick();                                  // ARM: prev = FFFF_FFFE
      chk("wrap pre valid", W'(sample_valid), '0);
      displacement = 32'h0000_0003;
      tick();
      chk("wrap delta",  sample_delta, 32'd5);
      chk("wrap valid",  W'(sample_valid), 32'd1);
      displacement = 32'h0000_0000;
      sample_ready = 1'b1;                     // accept and new sample on same edge
      tick();
      chk("rev delta",   sample_delta, 32'hFFFF_FFFD);
      chk("rev valid",   W'(sample_valid), 32'd1);
      chk("rev overrun", W'(sample_overrun), '0);
      sample_ready = 1'b0;
      tick();
      chk("zero delta",  sample_delta, '0);
      chk("zero valid",  W'(sample_valid), 32'd1);

      // ---------------- reset while a sample is pending ----------------
      rst_n = 1'b0;
      tick();
      chk("rst valid",   W'(sample_valid), '0);
      chk("rst fault",   W'(fault), '0);
      chk("rst overrun", W'(sample_overrun), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
